// File: rtl/frogger_pkg.sv
// Shared playfield constants and object/mode/direction codes for the obstacle lanes.
package frogger_pkg;
  localparam int GAME_WIDTH  = 20;
  localparam int GAME_HEIGHT = 15;
  localparam int COORD_W     = 6;
  localparam int TILE_SIZE   = 32;

  localparam logic [1:0] OBJ_NONE = 2'd0;
  localparam logic [1:0] OBJ_CAR  = 2'd1;
  localparam logic [1:0] OBJ_LOG  = 2'd2;

  localparam logic MODE_CAR = 1'b0;
  localparam logic MODE_LOG = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/lane_unit.sv
// One scrolling lane: position/count/config registers, stepping, and wrap-aware
// occupancy checks for a renderer column and the frog column.
module lane_unit #(
  parameter int   LANE_IDX       = 0,
  parameter int   GAME_WIDTH     = frogger_pkg::GAME_WIDTH,
  parameter int   COORD_W        = frogger_pkg::COORD_W,
  parameter int   OBJ_LEN        = 2,
  parameter int   PERIOD_W       = 8,
  parameter int   DEFAULT_PERIOD = 6,
  parameter int   STAGGER        = 3,
  parameter logic RESET_MODE     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_en,
  input  logic                cfg_wr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_dir,
  input  logic                cfg_mode,
  input  logic [COORD_W-1:0]  col_x,
  input  logic [COORD_W-1:0]  frog_x,
  output logic                occ_col,
  output logic                occ_frog,
  output logic                moved,
  output logic                mode,
  output logic                dir
);
  import frogger_pkg::*;

  localparam logic [COORD_W-1:0]  RST_POS    = COORD_W'((LANE_IDX * STAGGER) % GAME_WIDTH);
  localparam logic [COORD_W-1:0]  LAST_POS   = COORD_W'(GAME_WIDTH - 1);
  localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic                RST_DIR    = 1'(LANE_IDX % 2);
  localparam logic [COORD_W:0]    WIDTH_EXT  = (COORD_W+1)'(GAME_WIDTH);
  localparam logic [COORD_W:0]    LEN_EXT    = (COORD_W+1)'(OBJ_LEN);

  logic [COORD_W-1:0]  pos;
  logic [COORD_W-1:0]  next_pos;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] period;

  // Distance from the object head to x, folded back into 0..GAME_WIDTH-1.
  function automatic logic covers(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] p);
    logic [COORD_W:0] d;
    d = {1'b0, x} - {1'b0, p};
    if (d[COORD_W]) d = d + WIDTH_EXT;
    return d < LEN_EXT;
  endfunction

  assign occ_col  = covers(col_x, pos);
  assign occ_frog = covers(frog_x, pos);
  // A config write on the same cycle pre-empts any step.
  assign moved    = step_en && !cfg_wr && (period != '0) && (count == period - PERIOD_W'(1));

  always_comb begin
    next_pos = pos;
    if (dir == DIR_RIGHT) next_pos = (pos == LAST_POS) ? '0 : pos + COORD_W'(1);
    else                  next_pos = (pos == '0) ? LAST_POS : pos - COORD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos    <= RST_POS;
      count  <= '0;
      period <= RST_PERIOD;
      dir    <= RST_DIR;
      mode   <= RESET_MODE;
    end else if (cfg_wr) begin
      period <= cfg_period;
      dir    <= cfg_dir;
      mode   <= cfg_mode;
      count  <= '0;
    end else if (step_en && period != '0) begin
      if (moved) begin
        count <= '0;
        pos   <= next_pos;
      end else begin
        count <= count + PERIOD_W'(1);
      end
    end
  end
endmodule

// File: rtl/lane_engine.sv
// NUM_LANES scrolling car/log lanes with a renderer tile query and frog
// hazard / on-log / carry outputs, reduced from per-lane results by row select.
module lane_engine #(
  parameter int NUM_LANES      = 8,
  parameter int NUM_CAR_LANES  = 5,
  parameter int FIRST_ROW      = 1,
  parameter int GAME_WIDTH     = 20,
  parameter int COORD_W        = 6,
  parameter int OBJ_LEN        = 2,
  parameter int PERIOD_W       = 8,
  parameter int DEFAULT_PERIOD = 6,
  parameter int STAGGER        = 3,
  localparam int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Run,
  input  logic                i_Frame_Tick,
  input  logic                i_Cfg_Wr,
  input  logic [LANE_W-1:0]   i_Cfg_Lane,
  input  logic [PERIOD_W-1:0] i_Cfg_Period,
  input  logic                i_Cfg_Dir,
  input  logic                i_Cfg_Mode,
  input  logic [4:0]          i_Col_Div,
  input  logic [4:0]          i_Row_Div,
  input  logic [COORD_W-1:0]  i_Frog_X,
  input  logic [COORD_W-1:0]  i_Frog_Y,
  output logic [1:0]          o_Tile_Obj,
  output logic                o_Collided,
  output logic                o_On_Log,
  output logic                o_Carry_Valid,
  output logic                o_Carry_Dir
);
  import frogger_pkg::*;

  logic                 step_en;
  logic [NUM_LANES-1:0] occ_col, occ_frog, moved, lane_mode, lane_dir;
  logic [1:0]           tile_next;
  logic                 frog_row_hit, frog_in, frog_log;
  logic                 carry_hit, carry_dir_next;
  logic                 hazard, on_log_next, hazard_q;

  assign step_en = i_Frame_Tick && i_Run;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_unit #(
      .LANE_IDX      (k),
      .GAME_WIDTH    (GAME_WIDTH),
      .COORD_W       (COORD_W),
      .OBJ_LEN       (OBJ_LEN),
      .PERIOD_W      (PERIOD_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .STAGGER       (STAGGER),
      .RESET_MODE    ((k < NUM_CAR_LANES) ? MODE_CAR : MODE_LOG)
    ) u_lane (
      .clk       (i_Clk),
      .rst_n     (i_Rst_L),
      .step_en   (step_en),
      .cfg_wr    (i_Cfg_Wr && (i_Cfg_Lane == LANE_W'(k))),
      .cfg_period(i_Cfg_Period),
      .cfg_dir   (i_Cfg_Dir),
      .cfg_mode  (i_Cfg_Mode),
      .col_x     (COORD_W'(i_Col_Div)),
      .frog_x    (i_Frog_X),
      .occ_col   (occ_col[k]),
      .occ_frog  (occ_frog[k]),
      .moved     (moved[k]),
      .mode      (lane_mode[k]),
      .dir       (lane_dir[k])
    );
  end

  always_comb begin
    tile_next      = OBJ_NONE;
    frog_row_hit   = 1'b0;
    frog_in        = 1'b0;
    frog_log       = 1'b0;
    carry_hit      = 1'b0;
    carry_dir_next = DIR_RIGHT;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (int'(i_Row_Div) == FIRST_ROW + k && int'(i_Col_Div) < GAME_WIDTH && occ_col[k])
        tile_next = (lane_mode[k] == MODE_LOG) ? OBJ_LOG : OBJ_CAR;
      if (int'(i_Frog_Y) == FIRST_ROW + k) begin
        frog_row_hit   = 1'b1;
        frog_in        = occ_frog[k];
        frog_log       = lane_mode[k];
        carry_hit      = moved[k] && (lane_mode[k] == MODE_LOG) && occ_frog[k];
        carry_dir_next = lane_dir[k];
      end
    end
  end

  assign hazard      = i_Run && frog_row_hit && (frog_log ? !frog_in : frog_in);
  assign on_log_next = i_Run && frog_row_hit && frog_log && frog_in;

  // o_Carry_Valid is a one-cycle strobe with no ready/back-pressure; the
  // consumer must act on it that cycle. o_Carry_Dir is 0 whenever it is low.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Tile_Obj    <= OBJ_NONE;
      o_Collided    <= 1'b0;
      hazard_q      <= 1'b0;
      o_On_Log      <= 1'b0;
      o_Carry_Valid <= 1'b0;
      o_Carry_Dir   <= DIR_RIGHT;
    end else begin
      o_Tile_Obj    <= tile_next;
      o_Collided    <= hazard && !hazard_q;
      hazard_q      <= hazard;
      o_On_Log      <= on_log_next;
      o_Carry_Valid <= carry_hit;
      o_Carry_Dir   <= carry_hit ? carry_dir_next : DIR_RIGHT;
    end
  end
endmodule

// File: tb/tb_lane_engine.sv
// Bench for lane_engine: directed scenarios plus random traffic, all outputs
// scored every cycle against a position/count model of the lanes.
module tb_lane_engine;
  localparam int NL = 8;
  localparam int NCAR = 5;
  localparam int FR = 1;
  localparam int GW = 20;
  localparam int OL = 2;
  localparam int DEF_PER = 6;
  localparam int STAG = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_l = 1'b0, run = 1'b0, tick = 1'b0, cfg_wr = 1'b0;
  logic [2:0] cfg_lane = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_dir = 1'b0, cfg_mode = 1'b0;
  logic [4:0] col_div = '0, row_div = '0;
  logic [5:0] frog_x = '0, frog_y = '0;
  logic [1:0] tile_obj;
  logic       collided, on_log, carry_valid, carry_dir;

  lane_engine dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Run(run), .i_Frame_Tick(tick),
    .i_Cfg_Wr(cfg_wr), .i_Cfg_Lane(cfg_lane), .i_Cfg_Period(cfg_period),
    .i_Cfg_Dir(cfg_dir), .i_Cfg_Mode(cfg_mode),
    .i_Col_Div(col_div), .i_Row_Div(row_div),
    .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
    .o_Tile_Obj(tile_obj), .o_Collided(collided), .o_On_Log(on_log),
    .o_Carry_Valid(carry_valid), .o_Carry_Dir(carry_dir)
  );

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q[$];

  // reference model
  int m_pos[NL], m_cnt[NL], m_per[NL];
  bit m_dir[NL], m_mode[NL];
  bit m_hist;

  function automatic bit in_obj(int k, int x);
    return (((x - m_pos[k]) % GW + GW) % GW) < OL;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      m_pos[k]  = (k * STAG) % GW;
      m_cnt[k]  = 0;
      m_per[k]  = DEF_PER;
      m_dir[k]  = bit'(k % 2);
      m_mode[k] = (k >= NCAR);
    end
    m_hist = 0;
  endtask

  task automatic model_edge();
    int tile, fk, r, c, fx, fy;
    bit fv, fin, hz, coll, onl, cv, cd, wr, stp;
    if (!rst_l) begin
      model_reset();
      exp_q.push_back(6'd0);
      return;
    end
    r = int'(row_div); c = int'(col_div); fx = int'(frog_x); fy = int'(frog_y);
    tile = 0;
    if (r >= FR && r < FR + NL && c < GW && in_obj(r - FR, c))
      tile = m_mode[r - FR] ? 2 : 1;
    fv  = (fy >= FR && fy < FR + NL);
    fk  = fv ? fy - FR : 0;
    fin = fv && in_obj(fk, fx);
    hz  = run && fv && (m_mode[fk] ? !fin : fin);
    coll = hz && !m_hist;
    m_hist = hz;
    onl = run && fv && m_mode[fk] && fin;
    cv = 0; cd = 0;
    for (int k = 0; k < NL; k++) begin
      wr  = cfg_wr && (int'(cfg_lane) == k);
      stp = !wr && tick && run && m_per[k] != 0 && m_cnt[k] == m_per[k] - 1;
      if (fv && k == fk && stp && m_mode[k] && fin) begin
        cv = 1; cd = m_dir[k];
      end
      if (wr) begin
        m_per[k] = int'(cfg_period); m_dir[k] = cfg_dir; m_mode[k] = cfg_mode; m_cnt[k] = 0;
      end else if (tick && run && m_per[k] != 0) begin
        if (stp) begin
          m_cnt[k] = 0;
          m_pos[k] = (m_pos[k] + (m_dir[k] ? GW - 1 : 1)) % GW;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    exp_q.push_back({2'(tile), coll, onl, cv, cd});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // scoreboard monitor
  initial begin
    logic [5:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {tile_obj, collided, on_log, carry_valid, carry_dir};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL sb t=%0t: got tile=%0d coll=%0d onlog=%0d cv=%0d cd=%0d want tile=%0d coll=%0d onlog=%0d cv=%0d cd=%0d",
                   $time, a[5:4], a[3], a[2], a[1], a[0], e[5:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tick = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      step();
      tick = 1'b1;
      step();
    end
  endtask

  task automatic cfg(input int lane, input int per, input bit d, input bit m, input bit with_tick);
    step();
    cfg_wr = 1'b1; cfg_lane = 3'(lane); cfg_period = 8'(per);
    cfg_dir = d; cfg_mode = m; tick = with_tick;
  endtask

  task automatic tile_chk(input int c, input int r, input int e, input string name);
    step();
    col_div = 5'(c); row_div = 5'(r);
    step();
    chk(name, int'(tile_obj), e);
  endtask

  task automatic set_frog(input int x, input int y);
    step();
    frog_x = 6'(x); frog_y = 6'(y);
  endtask

  initial begin
    repeat (3) step();
    rst_l = 1'b1;

    // reset layout
    tile_chk(0, 1, 1, "rst_r1c0");
    tile_chk(1, 1, 1, "rst_r1c1");
    tile_chk(2, 1, 0, "rst_r1c2");
    tile_chk(3, 2, 1, "rst_r2c3");
    tile_chk(4, 2, 1, "rst_r2c4");
    tile_chk(5, 2, 0, "rst_r2c5");
    tile_chk(15, 6, 2, "rst_log5");
    tile_chk(0, 0, 0, "rst_row0");

    // stepping and wrap of lane 0
    step(); run = 1'b1;
    tick_n(5);
    tile_chk(2, 1, 0, "tick5_c2");
    tick_n(1);
    tile_chk(2, 1, 1, "tick6_c2");
    tile_chk(0, 1, 0, "tick6_c0");
    tick_n(114);
    tile_chk(0, 1, 1, "tick120_c0");
    tile_chk(2, 1, 0, "tick120_c2");

    // left wrap and right-edge straddle
    cfg(0, 1, 1'b1, 1'b0, 1'b0);
    tick_n(1);
    tile_chk(19, 1, 1, "left_c19");
    tile_chk(0, 1, 1, "left_c0");
    tile_chk(1, 1, 0, "left_c1");
    tile_chk(20, 1, 0, "col_out_range");
    cfg(0, 0, 1'b1, 1'b0, 1'b0);

    // collision pulses
    set_frog(0, 1);
    step(); chk("coll_first", collided, 1);
    step(); chk("coll_hold", collided, 0);
    repeat (3) step();
    chk("coll_hold2", collided, 0);
    set_frog(5, 1);
    step();
    set_frog(0, 1);
    step(); chk("coll_again", collided, 1);
    step(); chk("coll_again_end", collided, 0);

    // log ride and carry
    set_frog(0, 0);
    cfg(5, 1, 1'b0, 1'b1, 1'b0);
    tick_n(9);
    tile_chk(4, 6, 2, "log_pos4");
    tile_chk(3, 6, 0, "log_pos4_c3");
    cfg(5, 3, 1'b0, 1'b1, 1'b0);
    set_frog(5, 6);
    step(); chk("on_log", on_log, 1); chk("on_log_coll", collided, 0);
    tick_n(2);
    chk("no_carry_yet", carry_valid, 0);
    step(); tick = 1'b1;
    step(); chk("carry_valid", carry_valid, 1); chk("carry_dir", carry_dir, 0);
    step(); chk("carry_end", carry_valid, 0);
    set_frog(10, 6);
    step(); chk("water_coll", collided, 1); chk("water_onlog", on_log, 0);

    // frozen while not running
    step(); run = 1'b0;
    tick_n(20);
    chk("frozen_coll", collided, 0);
    tile_chk(5, 6, 2, "frozen_c5");
    tile_chk(7, 6, 0, "frozen_c7");

    // config write beats a coinciding step
    set_frog(0, 0);
    step(); run = 1'b1;
    cfg(5, 2, 1'b0, 1'b1, 1'b0);
    tick_n(1);
    cfg(5, 2, 1'b0, 1'b1, 1'b1);
    tick_n(1);
    tile_chk(5, 6, 2, "wr_wins");
    tick_n(1);
    tile_chk(5, 6, 0, "after_wr_c5");
    tile_chk(7, 6, 2, "after_wr_c7");

    // reset with a tick and a write pending
    set_frog(0, 1);
    step(); rst_l = 1'b0; tick = 1'b1; cfg_wr = 1'b1; cfg_lane = 3'd0; cfg_period = 8'd1;
    step();
    chk("rstmid_tile", tile_obj, 0); chk("rstmid_coll", collided, 0);
    chk("rstmid_carry", carry_valid, 0);
    rst_l = 1'b1;
    set_frog(0, 0);
    tile_chk(0, 1, 1, "rstmid_r1c0");
    tile_chk(2, 1, 0, "rstmid_r1c2");
    tile_chk(15, 6, 2, "rstmid_log5");

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      rst_l      = ($urandom_range(0, 599) != 0);
      run        = ($urandom_range(0, 15) != 0);
      tick       = ($urandom_range(0, 2) == 0);
      cfg_wr     = ($urandom_range(0, 9) == 0);
      cfg_lane   = 3'($urandom_range(0, 7));
      cfg_period = 8'($urandom_range(0, 4));
      cfg_dir    = 1'($urandom_range(0, 1));
      cfg_mode   = 1'($urandom_range(0, 1));
      col_div    = 5'($urandom_range(0, 31));
      row_div    = 5'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) begin
        frog_x = 6'($urandom_range(0, GW - 1));
        frog_y = 6'($urandom_range(0, 10));
      end
    end
    step(); rst_l = 1'b1;
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
